bus_arbiter: RTL and testbench

Two-requester arbiter sharing the single system memory bus between the RISC-V core (requester 0) and the debug module's system-bus-access port (requester 1). Holds at most one transaction in flight, routes the response back to its owner, and terminates hung accesses with an error response after a bounded timeout. Sits between the requesters and the memory subordinate in the system top level.

---
 rtl/bus_arbiter_pkg.sv | 18 +
 rtl/arb_grant.sv | 44 ++++
 rtl/bus_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg
//   Shared types and constants for the bus_arbiter slice.
//   - state_e        : arbiter FSM states (IDLE, ISSUE, WAIT)
//   - CORE / DEBUG   : requester indices (RISC-V core, debug system-bus access)
//   - NumRequesters  : number of requesters sharing the bus
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int unsigned CORE          = 0;
  localparam int unsigned DEBUG         = 1;
  localparam int unsigned NumRequesters = 2;

endpackage

// File: rtl/arb_grant.sv
// arb_grant
//   Combinational two-way grant.
//   Configuration macro: BUS_ARBITER__ROUND_ROBIN_EN
//     defined   : on a tie the requester that did not win last time is granted
//     undefined : fixed priority, DEBUG always wins a tie (last_grant_i ignored)
//   Ports:
//     valid_i      [2] request valid per requester
//     last_grant_i     index of the most recently accepted requester
//     grant_o      [2] one-hot grant (all zero when nothing is valid)
//     grant_idx_o      index of the granted requester
module arb_grant
  import bus_arbiter_pkg::*;
(
  input  logic [NumRequesters-1:0] valid_i,
  input  logic                     last_grant_i,
  output logic [NumRequesters-1:0] grant_o,
  output logic                     grant_idx_o
);

  logic tie_winner;

`ifdef BUS_ARBITER__ROUND_ROBIN_EN
  assign tie_winner = ~last_grant_i;
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
  assign tie_winner        = 1'(DEBUG);
`endif

  always_comb begin
    grant_o     = '0;
    grant_idx_o = 1'b0;
    if (valid_i == '1) begin
      grant_idx_o = tie_winner;
    end else begin
      // A lone requester wins regardless of history.
      grant_idx_o = valid_i[DEBUG];
    end
    if (|valid_i) begin
      grant_o[grant_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Shares one memory bus between the core (requester 0) and the debug
//   system-bus-access port (requester 1). One transaction in flight; the
//   response is routed back to its owner; hung accesses are terminated with
//   an error response after TimeoutCycles cycles in ISSUE/WAIT.
//   Configuration macro: BUS_ARBITER__ROUND_ROBIN_EN (round-robin tie-break,
//   otherwise debug wins ties).
//   Ports:
//     clk, rst_n                    clock, asynchronous active-low reset
//     req_valid/ready/write [2]     per-requester handshake and direction
//     req_addr/wdata/be     [2][*]  per-requester request fields
//     rsp_valid             [2]     one-cycle response pulse to the owner
//     rsp_rdata, rsp_error          shared response payload
//     mem_valid/write/addr/wdata/be downstream request
//     mem_ready                     downstream accept
//     mem_rsp_valid, mem_rdata      downstream response
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter  int unsigned DataWidth        = 32,
  parameter  int unsigned ByteAddressWidth = 32,
  parameter  int unsigned ByteSize         = 8,
  parameter  int unsigned TimeoutCycles    = 255,
  localparam int unsigned Lanes            = DataWidth / ByteSize
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NumRequesters-1:0]                      req_valid,
  output logic [NumRequesters-1:0]                      req_ready,
  input  logic [NumRequesters-1:0]                      req_write,
  input  logic [NumRequesters-1:0][ByteAddressWidth-1:0] req_addr,
  input  logic [NumRequesters-1:0][DataWidth-1:0]       req_wdata,
  input  logic [NumRequesters-1:0][Lanes-1:0]           req_be,
  output logic [NumRequesters-1:0]                      rsp_valid,
  output logic [DataWidth-1:0]                          rsp_rdata,
  output logic                                          rsp_error,
  output logic                                          mem_valid,
  output logic                                          mem_write,
  output logic [ByteAddressWidth-1:0]                   mem_addr,
  output logic [DataWidth-1:0]                          mem_wdata,
  output logic [Lanes-1:0]                              mem_be,
  input  logic                                          mem_ready,
  input  logic                                          mem_rsp_valid,
  input  logic [DataWidth-1:0]                          mem_rdata
);

  localparam int unsigned     CntW    = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  state_e                      state_q, state_d;
  logic                        owner_q;
  logic                        last_grant_q;
  logic                        write_q;
  logic [ByteAddressWidth-1:0] addr_q;
  logic [DataWidth-1:0]        wdata_q;
  logic [Lanes-1:0]            be_q;
  logic [CntW-1:0]             cnt_q;
  logic [NumRequesters-1:0]    rsp_valid_q;
  logic [DataWidth-1:0]        rsp_rdata_q;
  logic                        rsp_error_q;

  logic [NumRequesters-1:0]    grant;
  logic                        grant_idx;
  logic                        accept;
  logic                        expired;
  logic                        done_ok;
  logic                        done_err;

  arb_grant u_arb_grant (
    .valid_i      (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx)
  );

  // cnt_q holds (cycles spent in ISSUE/WAIT) - 1, so expiry is seen in the
  // TimeoutCycles-th such cycle. It saturates so a handshake landing on the
  // expiry cycle still leaves the following WAIT cycle expired.
  assign expired = (cnt_q >= CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Completion by the subordinate always outranks expiry in the same cycle.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    done_ok  = 1'b0;
    done_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          state_d = WAIT;
        end else if (expired) begin
          done_err = 1'b1;
          state_d  = IDLE;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          done_ok = 1'b1;
          state_d = IDLE;
        end else if (expired) begin
          done_err = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rst_n gates req_ready so nothing looks accepted while reset is held.
  always_comb begin
    req_ready = '0;
    mem_valid = 1'b0;
    if (state_q == IDLE && rst_n) begin
      req_ready = grant;
    end
    if (state_q == ISSUE) begin
      mem_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (accept) begin
        owner_q      <= grant_idx;
        last_grant_q <= grant_idx;
        write_q      <= req_write[grant_idx];
        addr_q       <= req_addr[grant_idx];
        wdata_q      <= req_wdata[grant_idx];
        be_q         <= req_be[grant_idx];
        cnt_q        <= '0;
      end else if (state_q != IDLE && cnt_q != CntMax) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (done_ok) begin
        rsp_valid_q[owner_q] <= 1'b1;
        rsp_rdata_q          <= write_q ? '0 : mem_rdata;
        rsp_error_q          <= 1'b0;
      end else if (done_err) begin
        rsp_valid_q[owner_q] <= 1'b1;
        rsp_rdata_q          <= '0;
        rsp_error_q          <= 1'b1;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign mem_write = write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

endmodule

// File: tb/tb_bus_arbiter.sv
`timescale 1ns/1ps
module tb_bus_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LN = 4;
  localparam int T  = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [1:0]             req_valid, req_ready, req_write, rsp_valid;
  logic [1:0][AW-1:0]     req_addr;
  logic [1:0][DW-1:0]     req_wdata;
  logic [1:0][LN-1:0]     req_be;
  logic [DW-1:0]          rsp_rdata;
  logic                   rsp_error;
  logic                   mem_valid, mem_write;
  logic [AW-1:0]          mem_addr;
  logic [DW-1:0]          mem_wdata;
  logic [LN-1:0]          mem_be;
  logic                   mem_ready, mem_rsp_valid;
  logic [DW-1:0]          mem_rdata;

  bus_arbiter #(
    .DataWidth        (DW),
    .ByteAddressWidth (AW),
    .ByteSize         (8),
    .TimeoutCycles    (T)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_be        (req_be),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_error     (rsp_error),
    .mem_valid     (mem_valid),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_ready     (mem_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model / memory-behaviour state
  logic        model_last = 1'b1;
  bit          busy = 0;
  int          acc_cyc = 0, exp_cyc = 0, mv_last = 0, acc_n = 0;
  int          rdy_cyc = -1, rsp_cyc = -1, stale_cyc = -1;
  logic [31:0] rsp_data = '0;
  logic        cur_write;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_be;
  bit          f_en = 0, f_hang = 0;
  int          f_dr = 0, f_ds = 1;
  logic [31:0] f_data = '0;
  bit          rand_mode = 0, drop_all = 0;
  logic [1:0]  clear_mask = '0, pend_en = '0, pend_w = '0;
  logic [1:0][31:0] pend_a, pend_d;
  logic [1:0][3:0]  pend_be;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic tie_pick();
`ifdef BUS_ARBITER__ROUND_ROBIN_EN
    return ~model_last;
`else
    return 1'b1;
`endif
  endfunction

  task automatic set_pend(input int i, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    pend_en[i] = 1'b1; pend_w[i] = wr; pend_a[i] = a; pend_d[i] = d; pend_be[i] = be;
  endtask

  // Expected response derived from the memory behaviour chosen for this transaction:
  // ready r cycles after acceptance, response s cycles after acceptance;
  // the access may occupy ISSUE/WAIT for at most T cycles, a handshake on
  // the last of them still wins and may extend by one WAIT cycle.
  task automatic plan(input logic w);
    int dr, ds, r, s, tlim;
    bit hang, has_r, ok;
    exp_t e;
    acc_cyc = cyc; acc_n++;
    cur_write = req_write[w]; cur_addr = req_addr[w];
    cur_wdata = req_wdata[w]; cur_be = req_be[w];
    if (f_en) begin
      dr = f_dr; ds = f_ds; hang = f_hang; rsp_data = f_data;
    end else begin
      dr = $urandom_range(0, 9); ds = $urandom_range(1, 4);
      hang = ($urandom_range(0, 9) == 0); rsp_data = $urandom;
    end
    if (rsp_cyc > cyc) stale_cyc = rsp_cyc;
    r = 1 + dr; s = r + ds;
    has_r = (r <= T);
    tlim = (r < T) ? T : T + 1;
    ok = has_r && !hang && (s <= tlim);
    rdy_cyc = has_r ? cyc + r : -1;
    rsp_cyc = (has_r && !hang && s <= T + 2) ? cyc + s : -1;
    mv_last = has_r ? r : T;
    e.owner = 2'b01 << w;
    if (ok) begin
      e.at = cyc + s + 1; e.err = 1'b0; e.rdata = cur_write ? 32'h0 : rsp_data;
    end else begin
      e.at = cyc + (has_r ? tlim : T) + 1; e.err = 1'b1; e.rdata = 32'h0;
    end
    exp_cyc = e.at;
    busy = 1;
    sbq.push_back(e);
  endtask

  task automatic sample();
    logic [1:0] er;
    logic w;
    bit idle, emv;
    int rel;
    idle = rst_n && (!busy || cyc >= exp_cyc);
    if (idle) busy = 0;
    er = '0; w = 1'b0;
    if (idle && req_valid != 2'b00) begin
      w = (req_valid == 2'b11) ? tie_pick() : req_valid[1];
      er[w] = 1'b1;
    end
    check("req_ready", 128'(req_ready), 128'(er));
    rel = cyc - acc_cyc;
    emv = busy && rel >= 1 && rel <= mv_last;
    check("mem_valid", 128'(mem_valid), 128'(emv));
    if (emv)
      check("mem_req", 128'({mem_write, mem_addr, mem_wdata, mem_be}),
            128'({cur_write, cur_addr, cur_wdata, cur_be}));
    if (er != 2'b00) begin
      model_last = w;
      clear_mask[w] = 1'b1;
      plan(w);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mem_ready     = (cyc == rdy_cyc);
    mem_rsp_valid = (cyc == rsp_cyc) || (cyc == stale_cyc);
    mem_rdata     = (cyc == rsp_cyc) ? rsp_data : $urandom;
    req_valid     = req_valid & ~clear_mask;
    clear_mask    = '0;
    if (drop_all) req_valid = '0;
    for (int i = 0; i < 2; i++) begin
      if (rand_mode && !req_valid[i] && !pend_en[i] && $urandom_range(0, 2) == 0)
        set_pend(i, 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(1, 15)));
      if (pend_en[i]) begin
        req_valid[i] = 1'b1; req_write[i] = pend_w[i]; req_addr[i] = pend_a[i];
        req_wdata[i] = pend_d[i]; req_be[i] = pend_be[i]; pend_en[i] = 1'b0;
      end
    end
    @(negedge clk);
    sample();
  endtask

  task automatic issue(input int i, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    int n0;
    n0 = acc_n;
    set_pend(i, wr, a, d, be);
    for (int k = 0; k < 40 && acc_n == n0; k++) step();
    check("accept_bound", 128'(acc_n != n0), 128'(1));
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (busy || sbq.size() != 0); k++) step();
    step();
    check("drain_idle", 128'({busy, sbq.size() != 0}), 128'(0));
  endtask

  task automatic force_plan(input int dr, input int ds, input bit hang, input logic [31:0] d);
    f_en = 1; f_dr = dr; f_ds = ds; f_hang = hang; f_data = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 128'(req_ready), 128'(0));
    check({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
    check({tag, "_rsp_rdata"}, 128'(rsp_rdata), 128'(0));
    check({tag, "_rsp_error"}, 128'(rsp_error), 128'(0));
    check({tag, "_mem_valid"}, 128'(mem_valid), 128'(0));
    check({tag, "_mem_fields"}, 128'({mem_write, mem_addr, mem_wdata, mem_be}), 128'(0));
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0 && cyc > sbq[0].at) begin
        check("rsp_at", 128'(cyc), 128'(sbq[0].at));
        void'(sbq.pop_front());
      end
      if (rsp_valid != 2'b00) begin
        if (sbq.size() == 0) begin
          check("rsp_unexpected", 128'(rsp_valid), 128'(0));
        end else begin
          e = sbq.pop_front();
          check("rsp_owner", 128'(rsp_valid), 128'(e.owner));
          check("rsp_rdata", 128'(rsp_rdata), 128'(e.rdata));
          check("rsp_error", 128'(rsp_error), 128'(e.err));
          check("rsp_cycle", 128'(cyc), 128'(e.at));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    mem_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    pend_a = '0; pend_d = '0; pend_be = '0;
    #3;
    check_reset_outputs("por");
    repeat (2) step();
    #2 rst_n = 1'b1;

    // Core read, best-case timing, 0xDEADBEEF
    force_plan(0, 1, 0, 32'hDEAD_BEEF);
    issue(0, 1'b0, 32'h100, 32'h0, 4'hF);
    drain();

    // Debug write held off by mem_ready for 5 cycles
    force_plan(5, 2, 0, 32'hFFFF_FFFF);
    issue(1, 1'b1, 32'h204, 32'h1234_5678, 4'b0011);
    drain();

    // Timeout with the late response landing in IDLE
    force_plan(5, 4, 0, 32'hA5A5_A5A5);
    issue(0, 1'b0, 32'h300, 32'h0, 4'hF);
    drain();

    // Pure hang with no response at all
    force_plan(0, 1, 1, 32'h0);
    issue(1, 1'b0, 32'h304, 32'h0, 4'hF);
    drain();

    // Response on the expiry cycle completes normally
    force_plan(0, T - 1, 0, 32'h0BAD_F00D);
    issue(0, 1'b0, 32'h308, 32'h0, 4'hF);
    drain();

    // Both requesting continuously
    force_plan(0, 1, 0, 32'h1111_2222);
    begin
      int n0;
      n0 = acc_n;
      for (int k = 0; k < 60 && acc_n < n0 + 4; k++) begin
        set_pend(0, 1'b0, 32'h400 + 32'(k), 32'h0, 4'hF);
        set_pend(1, 1'b0, 32'h800 + 32'(k), 32'h0, 4'hF);
        step();
      end
      check("tie_accepts", 128'(acc_n - n0 >= 4), 128'(1));
    end
    drop_all = 1; step(); drop_all = 0;
    drain();

    // Reset while in WAIT
    force_plan(0, 1, 1, 32'h0);
    issue(0, 1'b0, 32'h500, 32'h0, 4'hF);
    repeat (2) step();
    #2 rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    check_reset_outputs("midrst");
    req_valid = 2'b00;
    sbq.delete();
    busy = 0; rdy_cyc = -1; rsp_cyc = -1; stale_cyc = -1; model_last = 1'b1;
    repeat (2) step();
    #2 rst_n = 1'b1;
    repeat (3) step();
    force_plan(1, 2, 0, 32'hC0FF_EE00);
    issue(1, 1'b0, 32'h504, 32'h0, 4'hF);
    drain();

    // Randomized traffic
    f_en = 0;
    rand_mode = 1;
    repeat (1500) step();
    rand_mode = 0;
    drop_all = 1; step(); drop_all = 0;
    drain();

    check("sb_empty", 128'(sbq.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
